alu_mdu: RTL and testbench

//   Parametrised successor to the single-cycle execute ALU: the same 16 base ops plus RV32M multiply/divide.

---
 rtl/alu_mdu.sv | 199 +++++++++++++++++++
 tb/tb_alu_mdu.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU (16 base ops) plus RV32M multiply/divide on an iterative radix-2 datapath.
// Latency: base, illegal and divide special cases 1 cycle; MUL*/DIV*/REM* XLEN+2 cycles from accept to out_valid.
// Backpressure: in_ready drops while iterating or while a result is held with out_ready low; result stays stable until taken.
// Ports: clk/rst (sync, active-high); in_valid/in_ready + op1/op2/aluop request side;
//        out_valid/out_ready + result response side; busy flags an iterative op in flight.
module alu_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      aluop,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;        // MUL: upper accumulator; DIV: partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;        // MUL: multiplier / low product; DIV: dividend shifting into quotient
  logic [XLEN-1:0]   mcand_q, mcand_d;  // multiplicand or divisor magnitude
  logic [XLEN-1:0]   result_q, result_d;
  logic [2:0]        mop_q, mop_d;
  logic              neg_q, neg_d;      // negate the selected result in DONE
  logic              out_valid_q, out_valid_d;

  logic              accept;
  logic [SHW-1:0]    sh;
  logic [XLEN-1:0]   base_res;
  logic [XLEN-1:0]   min_v;
  logic              s1, s2, n1, n2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_zero, div_ovf;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh, div_diff;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   div_val, div_fix;

  function automatic logic [XLEN-1:0] zext(input logic b);
    return {{(XLEN-1){1'b0}}, b};
  endfunction

  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = (state_q != S_IDLE);
  assign sh        = op2[SHW-1:0];
  assign min_v     = {1'b1, {(XLEN-1){1'b0}}};

  always_comb begin
    base_res = '0;
    case (aluop[3:0])
      4'h0: base_res = op1 + op2;
      4'h1: base_res = op1 << sh;
      4'h2: base_res = zext($signed(op1) < $signed(op2));
      4'h3: base_res = zext(op1 < op2);
      4'h4: base_res = op1 ^ op2;
      4'h5: base_res = op1 >> sh;
      4'h6: base_res = op1 | op2;
      4'h7: base_res = op1 & op2;
      4'h8: base_res = op1 - op2;
      4'h9: base_res = zext(op1 == op2);
      4'hA: base_res = zext(op1 != op2);
      4'hB: base_res = zext($signed(op1) < $signed(op2));
      4'hC: base_res = zext($signed(op1) >= $signed(op2));
      4'hD: base_res = $unsigned($signed(op1) >>> sh);
      4'hE: base_res = zext(op1 < op2);
      4'hF: base_res = zext(op1 >= op2);
      default: base_res = '0;
    endcase
  end

  // Signedness by M op: MUL/MULH/DIV/REM both signed, MULHSU op1 only, U variants neither.
  always_comb begin
    s1       = (aluop[2:0] == 3'd0) || (aluop[2:0] == 3'd1) || (aluop[2:0] == 3'd2) ||
               (aluop[2:0] == 3'd4) || (aluop[2:0] == 3'd6);
    s2       = (aluop[2:0] == 3'd0) || (aluop[2:0] == 3'd1) ||
               (aluop[2:0] == 3'd4) || (aluop[2:0] == 3'd6);
    n1       = s1 && op1[XLEN-1];
    n2       = s2 && op2[XLEN-1];
    mag1     = n1 ? -op1 : op1;
    mag2     = n2 ? -op2 : op2;
    div_zero = (op2 == '0);
    div_ovf  = s1 && (op1 == min_v) && (op2 == '1);
  end

  // One iteration step for each datapath, plus the DONE-stage fix-up.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : {XLEN{1'b0}})};
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, mcand_q};
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    div_val  = mop_q[1] ? hi_q : lo_q;
    div_fix  = neg_q ? -div_val : div_val;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mcand_d     = mcand_q;
    mop_d       = mop_q;
    neg_d       = neg_q;
    result_d    = result_q;
    out_valid_d = out_valid_q && !out_ready;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!aluop[4]) begin
            result_d    = base_res;
            out_valid_d = 1'b1;
          end else if (aluop[3]) begin
            result_d    = '0;
            out_valid_d = 1'b1;
          end else if (aluop[2] && div_zero) begin
            result_d    = aluop[1] ? op1 : '1;
            out_valid_d = 1'b1;
          end else if (aluop[2] && div_ovf) begin
            result_d    = aluop[1] ? '0 : min_v;
            out_valid_d = 1'b1;
          end else begin
            state_d = aluop[2] ? S_DIV : S_MUL;
            cnt_d   = SHW'(XLEN-1);
            hi_d    = '0;
            lo_d    = mag1;
            mcand_d = mag2;
            mop_d   = aluop[2:0];
            // Remainder takes the dividend's sign; everything else the product/quotient sign.
            neg_d   = (aluop[2] && aluop[1]) ? n1 : (n1 ^ n2);
          end
        end
      end
      S_MUL: begin
        hi_d = mul_sum[XLEN:1];
        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - SHW'(1);
      end
      S_DIV: begin
        // Restoring step: keep the subtraction only when it did not borrow.
        if (!div_diff[XLEN]) begin
          hi_d = div_diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = div_sh[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - SHW'(1);
      end
      S_DONE: begin
        if (mop_q[2])             result_d = div_fix;
        else if (mop_q == 3'd0)   result_d = prod_fix[XLEN-1:0];
        else                      result_d = prod_fix[2*XLEN-1:XLEN];
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      mcand_q     <= '0;
      mop_q       <= '0;
      neg_q       <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mcand_q     <= mcand_d;
      mop_q       <= mop_d;
      neg_q       <= neg_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed table plus corner-case sequences on a 32-bit unit, random ops on 32- and 8-bit units.
// Latency: n/a (bench).
// Backpressure: bench drives out_ready, including multi-cycle stalls.
module tb_alu_mdu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] op1, op2, result;
  logic [4:0]  aluop;
  logic        in_valid_8, in_ready_8, out_valid_8, out_ready_8, busy_8;
  logic [7:0]  op1_8, op2_8, result_8;
  logic [4:0]  aluop_8;

  alu_mdu #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .aluop(aluop), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  alu_mdu #(.XLEN(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .op1(op1_8), .op2(op2_8), .aluop(aluop_8), .out_valid(out_valid_8),
    .out_ready(out_ready_8), .result(result_8), .busy(busy_8)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ex;
    int          lat;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, ex);
    end
  endtask

  task automatic add(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ex, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.ex = ex; v.lat = lat;
    tbl.push_back(v);
  endtask

  function automatic logic rdy(input bit w8);
    return w8 ? in_ready_8 : in_ready;
  endfunction
  function automatic logic ov(input bit w8);
    return w8 ? out_valid_8 : out_valid;
  endfunction
  function automatic logic bsy(input bit w8);
    return w8 ? busy_8 : busy;
  endfunction
  function automatic logic [31:0] res(input bit w8);
    return w8 ? {24'b0, result_8} : result;
  endfunction

  task automatic set_in(input bit w8, input logic v, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      in_valid_8 = v; aluop_8 = op; op1_8 = a[7:0]; op2_8 = b[7:0];
    end else begin
      in_valid = v; aluop = op; op1 = a; op2 = b;
    end
  endtask

  task automatic set_ordy(input bit w8, input logic v);
    if (w8) out_ready_8 = v;
    else    out_ready   = v;
  endtask

  // Reference model for any width up to 32, computed in 64-bit signed arithmetic.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input int w);
    longint one, m, ua, ub, sa, sb, mn, r;
    int sh;
    bit ovf;
    one = 1;
    m   = (one << w) - 1;
    ua  = {32'b0, a} & m;
    ub  = {32'b0, b} & m;
    sa  = ua; if (ua[w-1]) sa = ua - (one << w);
    sb  = ub; if (ub[w-1]) sb = ub - (one << w);
    mn  = one << (w-1);
    sh  = int'(ub & longint'(w-1));
    ovf = (sa == -mn) && (sb == -1);
    case (op)
      5'h00: r = ua + ub;
      5'h01: r = ua << sh;
      5'h02: r = (sa < sb) ? 1 : 0;
      5'h03: r = (ua < ub) ? 1 : 0;
      5'h04: r = ua ^ ub;
      5'h05: r = ua >> sh;
      5'h06: r = ua | ub;
      5'h07: r = ua & ub;
      5'h08: r = ua - ub;
      5'h09: r = (ua == ub) ? 1 : 0;
      5'h0A: r = (ua != ub) ? 1 : 0;
      5'h0B: r = (sa < sb) ? 1 : 0;
      5'h0C: r = (sa >= sb) ? 1 : 0;
      5'h0D: r = sa >>> sh;
      5'h0E: r = (ua < ub) ? 1 : 0;
      5'h0F: r = (ua >= ub) ? 1 : 0;
      5'h10: r = sa * sb;
      5'h11: r = (sa * sb) >> w;
      5'h12: r = (sa * ub) >> w;
      5'h13: r = (ua * ub) >> w;
      5'h14: r = (ub == 0) ? m  : (ovf ? ua : sa / sb);
      5'h15: r = (ub == 0) ? m  : ua / ub;
      5'h16: r = (ub == 0) ? ua : (ovf ? 0 : sa % sb);
      5'h17: r = (ub == 0) ? ua : ua % ub;
      default: r = 0;
    endcase
    r = r & m;
    return r[31:0];
  endfunction

  function automatic int lat_of(input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (!op[4] || op[3]) return 1;
    if (!op[2]) return w + 2;
    if ((b & m) == 32'd0) return 1;
    if ((op == 5'h14 || op == 5'h16) && ((a & m) == (32'd1 << (w-1))) && ((b & m) == m)) return 1;
    return w + 2;
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return m;
      2:       return 32'd1 << (w-1);
      3:       return 32'd1;
      default: return $urandom & m;
    endcase
  endfunction

  // Issue one op, measure accept-to-out_valid latency, check result, then hold for 'stall' cycles.
  task automatic do_op(input bit w8, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ex, input int ex_lat, input int stall, input string nm);
    int n;
    bit bad;
    @(negedge clk);
    set_ordy(w8, stall == 0);
    set_in(w8, 1'b1, op, a, b);
    #1;
    n = 0;
    while (!rdy(w8) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      check(1'b0, {nm, " in_ready timeout"}, 32'd0, 32'd1);
      set_in(w8, 1'b0, op, a, b);
      set_ordy(w8, 1'b1);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    set_in(w8, 1'b0, op, a, b);
    n = 1;
    bad = 1'b0;
    while (!ov(w8) && n < 200) begin
      if (!bsy(w8) || rdy(w8)) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    check(n == ex_lat, {nm, " latency"}, 32'(n), 32'(ex_lat));
    check(res(w8) == ex, {nm, " result"}, res(w8), ex);
    if (ex_lat > 1) check(!bad, {nm, " busy/in_ready while iterating"}, 32'(bad), 32'd0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check(ov(w8) && !rdy(w8) && res(w8) == ex, {nm, " hold"}, res(w8), ex);
    end
    set_ordy(w8, 1'b1);
  endtask

  initial begin
    logic [31:0] ex;
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    bit          w8, seen;
    int          w, n;

    add(5'h00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1);
    add(5'h01, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1);
    add(5'h0D, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1);
    add(5'h02, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);
    add(5'h03, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
    add(5'h08, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1);
    add(5'h04, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
    add(5'h05, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1);
    add(5'h06, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1);
    add(5'h07, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
    add(5'h09, 32'h0000_0005, 32'h0000_0005, 32'h0000_0001, 1);
    add(5'h0A, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1);
    add(5'h0C, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
    add(5'h0E, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1);
    add(5'h0F, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    add(5'h10, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 34);
    add(5'h10, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 34);
    add(5'h11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    add(5'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    add(5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    add(5'h14, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34);
    add(5'h16, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34);
    add(5'h14, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    add(5'h16, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34);
    add(5'h15, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 34);
    add(5'h17, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 34);
    add(5'h15, 32'h0000_04D2, 32'h0000_0000, 32'hFFFF_FFFF, 1);
    add(5'h16, 32'h0000_04D2, 32'h0000_0000, 32'h0000_04D2, 1);
    add(5'h14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    add(5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    add(5'h18, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1);

    rst = 1'b1;
    set_in(1'b0, 1'b0, 5'h00, 32'd0, 32'd0);
    set_in(1'b1, 1'b0, 5'h00, 32'd0, 32'd0);
    out_ready = 1'b1;
    out_ready_8 = 1'b1;
    repeat (3) @(negedge clk);
    check(out_valid == 1'b0, "reset out_valid", 32'(out_valid), 32'd0);
    check(result == 32'd0, "reset result", result, 32'd0);
    check(busy == 1'b0, "reset busy", 32'(busy), 32'd0);
    check(out_valid_8 == 1'b0 && result_8 == 8'd0, "reset 8-bit", {24'b0, result_8}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check(in_ready == 1'b1, "in_ready after reset", 32'(in_ready), 32'd1);

    foreach (tbl[i])
      do_op(1'b0, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ex, tbl[i].lat, 0,
            $sformatf("vec%0d op%h", i, tbl[i].op));

    // Back-to-back ADDs: each negedge must show the previous op's sum.
    @(negedge clk);
    in_valid = 1'b1; aluop = 5'h00; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      op1 = 32'(k) * 32'd100;
      op2 = 32'(k) + 32'd1;
      ex  = 32'(k * 101 + 1);
      @(negedge clk);
      check(out_valid && result == ex, $sformatf("b2b add %0d", k), result, ex);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // MUL result held while out_ready is low; next op accepted on release.
    in_valid = 1'b1; aluop = 5'h10; op1 = 32'd7; op2 = 32'd6;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    check(out_valid == 1'b1, "hold mul out_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1; aluop = 5'h00; op1 = 32'd1; op2 = 32'd2;
    for (int s = 0; s < 5; s++) begin
      #1;
      check(out_valid && !in_ready && result == 32'd42, $sformatf("hold cycle %0d", s), result, 32'd42);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check(in_ready == 1'b1, "release in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check(out_valid && result == 32'd3, "op after release", result, 32'd3);

    // Reset in the middle of a DIVU iteration.
    @(negedge clk);
    in_valid = 1'b1; aluop = 5'h15; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check(busy == 1'b1, "divu busy before abort", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check(in_ready && !busy && !out_valid, "abort in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check(!seen, "abort no out_valid", 32'(seen), 32'd0);

    // Random ops on both widths with random output stalls.
    for (int i = 0; i < 160; i++) begin
      w8  = i[0];
      w   = w8 ? 8 : 32;
      rop = 5'($urandom_range(0, 31));
      ra  = pick(w);
      rb  = pick(w);
      do_op(w8, rop, ra, rb, model(rop, ra, rb, w), lat_of(rop, ra, rb, w),
            $urandom_range(0, 3), $sformatf("rnd%0d w%0d op%h a%h b%h", i, w, rop, ra, rb));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
